// File: rtl/color_seq_pkg.sv
// Shared mode, hue-phase and fade-direction encodings
// for the color sequencer family.
package color_seq_pkg;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_HUE   = 2'd1;
  localparam logic [1:0] MODE_FADE  = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  typedef enum logic [2:0] {
    H0 = 3'd0,
    H1 = 3'd1,
    H2 = 3'd2,
    H3 = 3'd3,
    H4 = 3'd4,
    H5 = 3'd5
  } hue_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/color_tick_prescaler.sv
// Enabled-cycle prescaler: tick once every step_div+1
// enabled cycles; clear restarts the count without a tick.
module color_tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = enable && !clear && (cnt == step_div);

  // count above a freshly lowered step_div falls back to 0 silently
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt >= step_div) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/color_sequencer.sv
// Registered RGB sequencer: linear count, rainbow hue
// sweep, grey ping-pong fade and hold, with wrap pulse.
module color_sequencer
  import color_seq_pkg::*;
#(
  parameter int CW    = 4,
  parameter int DIV_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [DIV_W-1:0] step_div,
  input  logic            load,
  input  logic [3*CW-1:0] load_color,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue,
  output logic            wrap
);

  localparam logic [CW-1:0] MAX = '1;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [3*CW-1:0] ONE3 = {{(3*CW-1){1'b0}}, 1'b1};

  logic [1:0] mode_q;
  hue_t       phase;
  logic       dir;
  logic       tick;
  logic       mode_chg;
  logic       load_ok;
  logic [3*CW-1:0] rgb;
  logic [3*CW-1:0] rgb_inc;

  assign rgb      = {red, green, blue};
  assign rgb_inc  = rgb + ONE3;
  assign mode_chg = (mode != mode_q);
  assign load_ok  = load &&
                    (mode_q == MODE_COUNT || mode_q == MODE_HOLD);

  color_tick_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    (mode_chg || load_ok),
    .step_div (step_div),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      wrap   <= 1'b0;
      mode_q <= MODE_COUNT;
      phase  <= H0;
      dir    <= DIR_UP;
    end else begin
      wrap <= 1'b0;
      if (mode_chg) begin
        mode_q <= mode;
        unique case (mode)
          MODE_HUE: begin
            {red, green, blue} <= {MAX, {CW{1'b0}}, {CW{1'b0}}};
            phase <= H0;
          end
          MODE_FADE: begin
            {red, green, blue} <= '0;
            dir <= DIR_UP;
          end
          default: ;
        endcase
      end else if (load_ok) begin
        {red, green, blue} <= load_color;
      end else if (tick) begin
        unique case (mode_q)
          MODE_COUNT: begin
            {red, green, blue} <= rgb_inc;
            wrap <= &rgb;
          end
          MODE_HUE: begin
            unique case (phase)
              H0: begin
                green <= green + ONE;
                if (green == MAX - ONE) phase <= H1;
              end
              H1: begin
                red <= red - ONE;
                if (red == ONE) phase <= H2;
              end
              H2: begin
                blue <= blue + ONE;
                if (blue == MAX - ONE) phase <= H3;
              end
              H3: begin
                green <= green - ONE;
                if (green == ONE) phase <= H4;
              end
              H4: begin
                red <= red + ONE;
                if (red == MAX - ONE) phase <= H5;
              end
              H5: begin
                blue <= blue - ONE;
                if (blue == ONE) begin
                  phase <= H0;
                  wrap  <= 1'b1;
                end
              end
              default: phase <= H0;
            endcase
          end
          MODE_FADE: begin
            if (dir == DIR_UP) begin
              red   <= red + ONE;
              green <= red + ONE;
              blue  <= red + ONE;
              if (red == MAX - ONE) dir <= DIR_DOWN;
            end else begin
              red   <= red - ONE;
              green <= red - ONE;
              blue  <= red - ONE;
              if (red == ONE) begin
                dir  <= DIR_UP;
                wrap <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer with CW=4.
module tb_color_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] step_div;
  logic        load;
  logic [11:0] load_color;
  logic [3:0]  red, green, blue;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  color_sequencer #(.CW(4), .DIV_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .step_div   (step_div),
    .load       (load),
    .load_color (load_color),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] hue_exp(input int i);
    int p, k;
    logic [3:0] kk, nk;
    p  = (i - 1) / 15;
    k  = (i - 1) % 15 + 1;
    kk = 4'(k);
    nk = 4'(15 - k);
    case (p)
      0: return {4'hF, kk, 4'h0};
      1: return {nk, 4'hF, 4'h0};
      2: return {4'h0, 4'hF, kk};
      3: return {4'h0, nk, 4'hF};
      4: return {kk, 4'h0, 4'hF};
      default: return {4'hF, 4'h0, nk};
    endcase
  endfunction

  function automatic logic [11:0] fade_exp(input int i);
    logic [3:0] l;
    l = (i <= 15) ? 4'(i) : 4'(30 - i);
    return {l, l, l};
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 2'd0;
    step_div = 16'd0; load = 1'b0; load_color = '0;
    step(); step();
    chk("reset_rgb", {red, green, blue}, 12'h000);
    chk("reset_wrap", wrap, 1'b0);
    reset = 1'b0;

    // COUNT wrap
    load = 1'b1; load_color = 12'hFFE;
    step();
    load = 1'b0;
    chk("cnt_load", {red, green, blue}, 12'hFFE);
    chk("cnt_load_wrap", wrap, 1'b0);
    step();
    chk("cnt_fff", {red, green, blue}, 12'hFFF);
    chk("cnt_fff_wrap", wrap, 1'b0);
    step();
    chk("cnt_000", {red, green, blue}, 12'h000);
    chk("cnt_wrap", wrap, 1'b1);
    step();
    chk("cnt_001", {red, green, blue}, 12'h001);
    chk("cnt_wrap_1cyc", wrap, 1'b0);

    // COUNT with prescaler and enable freeze
    load = 1'b1; load_color = 12'h000;
    step();
    load = 1'b0;
    step_div = 16'd2;
    for (int i = 0; i < 9; i++) step();
    chk("div_9cyc", {red, green, blue}, 12'h003);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("freeze_rgb", {red, green, blue}, 12'h003);
      chk("freeze_wrap", wrap, 1'b0);
    end
    enable = 1'b1;
    step(); step();
    chk("resume_2", {red, green, blue}, 12'h003);
    step();
    chk("resume_3", {red, green, blue}, 12'h004);

    // HUE full sweep
    step_div = 16'd0; mode = 2'd1;
    step();
    chk("hue_init", {red, green, blue}, 12'hF00);
    chk("hue_init_wrap", wrap, 1'b0);
    for (int i = 1; i <= 90; i++) begin
      step();
      chk("hue_rgb", {red, green, blue}, 32'(hue_exp(i)));
      chk("hue_wrap", wrap, 32'(i == 90));
    end

    // FADE full period
    mode = 2'd2;
    step();
    chk("fade_init", {red, green, blue}, 12'h000);
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("fade_rgb", {red, green, blue}, 32'(fade_exp(i)));
      chk("fade_wrap", wrap, 32'(i == 30));
    end
    step();
    chk("fade_31", {red, green, blue}, 12'h111);
    chk("fade_31_wrap", wrap, 1'b0);

    // Mode change mid-HUE into FADE clears prescaler
    mode = 2'd1;
    step();
    chk("hue2_init", {red, green, blue}, 12'hF00);
    for (int i = 1; i <= 35; i++) step();
    chk("hue2_h2", {red, green, blue}, 12'h0F5);
    step_div = 16'd3;
    step(); step();
    chk("hue2_wait", {red, green, blue}, 12'h0F5);
    mode = 2'd2;
    step();
    chk("chg_rgb", {red, green, blue}, 12'h000);
    chk("chg_wrap", wrap, 1'b0);
    step(); step(); step();
    chk("chg_presc0", {red, green, blue}, 12'h000);
    step();
    chk("chg_tick", {red, green, blue}, 12'h111);

    // load ignored in FADE
    step_div = 16'd0;
    load = 1'b1; load_color = 12'hABC;
    step();
    load = 1'b0;
    chk("fade_noload", {red, green, blue}, 12'h222);

    // HOLD load and hold
    mode = 2'd3;
    step();
    chk("hold_enter", {red, green, blue}, 12'h222);
    load = 1'b1; load_color = 12'hABC;
    step();
    load = 1'b0;
    chk("hold_load", {red, green, blue}, 12'hABC);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_rgb", {red, green, blue}, 12'hABC);
      chk("hold_wrap", wrap, 1'b0);
    end

    // Reset mid-FADE with a coincident tick
    mode = 2'd2;
    step();
    chk("fade2_init", {red, green, blue}, 12'h000);
    for (int i = 1; i <= 9; i++) step();
    chk("fade2_9", {red, green, blue}, 12'h999);
    reset = 1'b1;
    step();
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_mode_q", dut.mode_q, 2'd0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
- Parametrised successor to the widget color counter.
- Produces registered red/green/blue channel values of width CW for the VGA widget renderer.
- Runtime modes: linear count, six-phase rainbow hue sweep, grey ping-pong fade, and hold.
- A programmable prescaler sets the step rate; a one-cycle wrap pulse marks sequence completion.

Parameters:
- CW, 4, bits per color channel; MAX = 2^CW-1.
- DIV_W, 16, width of the step_div prescaler input.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  advance permitted; low freezes the prescaler and color state.
- mode  input  2  0 COUNT, 1 HUE, 2 FADE, 3 HOLD.
- step_div  input  DIV_W  steps occur every step_div+1 enabled cycles.
- load  input  1  load load_color (COUNT/HOLD only).
- load_color  input  3*CW  {r,g,b} value to load.
- red, green, blue  output  CW each  registered channel outputs.
- wrap  output  1  one-cycle pulse at sequence end.

Behaviour:
- Reset (synchronous): red/green/blue=0, wrap=0, prescaler=0, mode_q=COUNT, hue phase=H0, fade dir=up.
- Prescaler: when enable=1 it counts 0..step_div. tick=1 in the cycle count==step_div, and count returns to 0. step_div=0 gives a tick every enabled cycle. If step_div changes while count>step_div, the next cycle clears the count with no tick. enable=0 holds the count and suppresses tick.
- Priority per cycle: reset > mode change > load > tick > hold.
- Mode change (mode!=mode_q):
  - mode_q<=mode; prescaler<=0; no step this cycle.
  - Initial state loaded: COUNT keeps current color; HUE sets {MAX,0,0}, phase H0; FADE sets {0,0,0}, dir up; HOLD keeps color.
- load: honoured in COUNT and HOLD, where the color takes load_color next cycle and the prescaler is cleared. Ignored in HUE and FADE.
- COUNT, on tick: {r,g,b} <= {r,g,b}+1, modulo 2^(3*CW). wrap=1 on the transition all-ones -> 0.
- HUE, on tick: the active channel moves by 1. Phase advances when the active channel reaches its target, with the first step of the next phase on the following tick.
  - H0: G 0->MAX (R=MAX).
  - H1: R MAX->0.
  - H2: B 0->MAX.
  - H3: G MAX->0.
  - H4: R 0->MAX.
  - H5: B MAX->0, then H0.
  - Each phase takes MAX ticks; a full cycle is 6*MAX ticks.
  - wrap=1 on the tick that leaves H5 ({MAX,0,0} reached).
- FADE, on tick: all three channels equal L.
  - dir up: L+1. When L reaches MAX, dir<=down.
  - dir down: L-1. When L reaches 0, dir<=up and wrap=1.
  - Period is 2*MAX ticks.
- HOLD: color is static; tick ignored; wrap=0.
- wrap: registered and asserted exactly one cycle, coincident with the output update that completes the sequence. Never asserted on reset, mode change or load.
- Latency: outputs update the clock edge after the tick condition; all outputs come directly from flops.

Decomposition:
- Package color_seq_pkg:
  - mode constants MODE_COUNT/HUE/FADE/HOLD.
  - hue phase enum H0..H5 (3-bit).
  - fade direction constants.
- Sub-module color_tick_prescaler (DIV_W): clk, reset, enable, clear, step_div -> tick. Reused by other animated widgets.
- Mode datapaths live in one case-structured always block within color_sequencer.

Test Plan:
- CW=4, COUNT, step_div=0, load 0xFFE: after 1 tick 0xFFF, next tick 0x000 with wrap=1 for exactly one cycle.
- COUNT, step_div=2, enable=1 for 9 cycles from 0x000 -> color 0x003. Then enable=0 for 5 cycles -> color held and no tick.
- HUE, step_div=0:
  - after mode switch, color=F00.
  - 15 ticks -> FF0.
  - 30 ticks -> 0F0.
  - 90 ticks -> F00 with wrap pulse. Check every intermediate value.
- FADE: 15 ticks -> FFF; 30 ticks -> 000 with wrap=1; tick 31 -> 111.
- Mode change mid-HUE (color at phase H2) to FADE -> next cycle 000, prescaler 0, no wrap. load asserted in FADE is ignored; load 0xABC in HOLD -> 0xABC, stays there for 20 ticks.
- Reset asserted mid-FADE at L=9 with tick coincident -> next cycle all outputs 0, mode_q=COUNT, wrap=0.
